uart_led_cmd: RTL and testbench

//  Command interpreter downstream of the full-duplex UART core. Pops ASCII bytes from the UART RX FIFO and

---
 rtl/uart_led_pkg.sv | 31 +++
 rtl/uart_led_if.sv | 21 ++
 rtl/uart_led_cmd_hex_codec.sv | 23 ++
 rtl/uart_led_cmd.sv | 179 +++++++++++++++++
 tb/tb_uart_led_cmd.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_led_pkg.sv
// Shared constants and types for the UART LED command interpreter.
package uart_led_pkg;

    localparam int unsigned DBITS_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 5_000_000;
    localparam int unsigned TO_BITS_DEF = 23;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_Q  = 8'h3F;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Command decode happens inside IDLE on the popped byte, so no separate CMD cycle exists.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_TOGGLE,
        OP_READ
    } op_t;

endpackage

// File: rtl/uart_led_if.sv
// FIFO-side handshake between the UART core (slave) and the command interpreter (master).
interface uart_led_if #(
    parameter int unsigned DBITS = uart_led_pkg::DBITS_DEF
);
    logic             rx_empty;
    logic [DBITS-1:0] read_data;
    logic             read_uart;
    logic             tx_full;
    logic             write_uart;
    logic [DBITS-1:0] write_data;

    modport master (
        input  rx_empty, read_data, tx_full,
        output read_uart, write_uart, write_data
    );

    modport slave (
        output rx_empty, read_data, tx_full,
        input  read_uart, write_uart, write_data
    );
endinterface

// File: rtl/uart_led_cmd_hex_codec.sv
// Combinational ASCII hex codec: ascii -> {valid, nibble} and nibble -> uppercase ascii.
module hex_codec (
    input  logic [7:0] ascii,
    output logic       valid_c,
    output logic [3:0] nibble_c,
    input  logic [3:0] nibble,
    output logic [7:0] ascii_c
);
    always_comb begin
        valid_c  = 1'b1;
        nibble_c = 4'h0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble_c = 4'(ascii - 8'h30);
        end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
            nibble_c = 4'(ascii - 8'h37);
        end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
            nibble_c = 4'(ascii - 8'h57);
        end else begin
            valid_c = 1'b0;
        end
        ascii_c = (nibble < 4'd10) ? (8'h30 + 8'(nibble)) : (8'h37 + 8'(nibble));
    end
endmodule

// File: rtl/uart_led_cmd.sv
// Command interpreter: pops ASCII commands from the UART RX FIFO, drives the LED register,
// and pushes ASCII replies into the UART TX FIFO.
module uart_led_cmd
    import uart_led_pkg::*;
#(
    parameter int unsigned DBITS   = DBITS_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_BITS = TO_BITS_DEF
) (
    input  logic        clk_50Mhz,
    input  logic        rst,
    uart_led_if.master  bus,
    output logic [7:0]  led,
    output logic        busy,
    output logic [7:0]  err_count
);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [3:0]        hi_q, hi_d, lo_q, lo_d;
    logic [7:0]        led_q, led_d;
    logic [7:0]        err_q, err_d;
    logic [2:0][7:0]   buf_q, buf_d;
    logic [1:0]        idx_q, idx_d;
    logic [TO_BITS-1:0] to_q, to_d;
    logic              busy_q;
    logic              err_inc, rd_c, wr_c;

    logic [7:0] rx_byte;
    logic       dec_valid;
    logic [3:0] dec_nib;
    logic [3:0] enc_nib;
    logic [7:0] enc_ascii;
    logic [7:0] unused_dec_ascii;
    logic       unused_enc_valid;
    logic [3:0] unused_enc_nib;

    assign rx_byte = 8'(bus.read_data);

    hex_codec u_dec (
        .ascii    (rx_byte),
        .valid_c  (dec_valid),
        .nibble_c (dec_nib),
        .nibble   (4'h0),
        .ascii_c  (unused_dec_ascii)
    );

    hex_codec u_enc (
        .ascii    (8'h00),
        .valid_c  (unused_enc_valid),
        .nibble_c (unused_enc_nib),
        .nibble   (enc_nib),
        .ascii_c  (enc_ascii)
    );

    // Next-state, datapath updates and FIFO strobes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        led_d   = led_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        to_d    = '0;
        err_inc = 1'b0;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        // Single encoder: high nibble while loading the reply, low nibble once RESP starts.
        enc_nib = (state_q == ST_EXEC) ? led_q[7:4] : led_q[3:0];

        case (state_q)
            ST_IDLE: begin
                if (!bus.rx_empty) begin
                    rd_c = 1'b1;
                    case (rx_byte)
                        ASCII_L: begin op_d = OP_LOAD;   state_d = ST_HI;   end
                        ASCII_T: begin op_d = OP_TOGGLE; state_d = ST_HI;   end
                        ASCII_R: begin op_d = OP_READ;   state_d = ST_EXEC; end
                        ASCII_CR, ASCII_LF: ;
                        default: begin
                            err_inc  = 1'b1;
                            buf_d[0] = ASCII_Q;
                            idx_d    = 2'd0;
                            state_d  = ST_RESP;
                        end
                    endcase
                end
            end
            ST_HI, ST_LO: begin
                if (!bus.rx_empty) begin
                    rd_c = 1'b1;
                    if (!dec_valid) begin
                        err_inc  = 1'b1;
                        buf_d[0] = ASCII_Q;
                        idx_d    = 2'd0;
                        state_d  = ST_RESP;
                    end else if (state_q == ST_HI) begin
                        hi_d    = dec_nib;
                        state_d = ST_LO;
                    end else begin
                        lo_d    = dec_nib;
                        state_d = ST_EXEC;
                    end
                end else if (to_q == TO_LAST) begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + TO_BITS'(1);
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                case (op_q)
                    OP_LOAD:   begin led_d = {hi_q, lo_q};         buf_d[0] = ASCII_K; idx_d = 2'd0; end
                    OP_TOGGLE: begin led_d = led_q ^ {hi_q, lo_q}; buf_d[0] = ASCII_K; idx_d = 2'd0; end
                    default: begin
                        buf_d[2] = enc_ascii;
                        buf_d[0] = ASCII_LF;
                        idx_d    = 2'd2;
                    end
                endcase
            end
            ST_RESP: begin
                if (idx_q == 2'd2) begin
                    buf_d[1] = enc_ascii;
                end
                if (!bus.tx_full) begin
                    wr_c = 1'b1;
                    if (idx_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? (err_q + 8'd1) : err_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            hi_q    <= '0;
            lo_q    <= '0;
            led_q   <= '0;
            err_q   <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            to_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            led_q   <= led_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // FIFO strobes are same-cycle with the FIFO flags; reset forces them low immediately.
    assign bus.read_uart  = rd_c & rst;
    assign bus.write_uart = wr_c & rst;
    assign bus.write_data = DBITS'(buf_q[idx_q]);
    assign led            = led_q;
    assign busy           = busy_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_uart_led_cmd.sv
// Randomized scoreboard bench for uart_led_cmd with a string-level reference interpreter.
module tb_uart_led_cmd;
    localparam int unsigned T_OUT = 100;

    typedef logic [7:0] u8_t;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] led, err_count;
    logic busy;

    always #5 clk = ~clk;

    uart_led_if #(.DBITS(8)) bus ();

    uart_led_cmd #(.DBITS(8), .TIMEOUT(T_OUT), .TO_BITS(7)) dut (
        .clk_50Mhz (clk),
        .rst       (rst),
        .bus       (bus),
        .led       (led),
        .busy      (busy),
        .err_count (err_count)
    );

    u8_t rx_q[$];
    u8_t exp_q[$];
    int  wr_cyc[$];
    int  checks = 0, errors = 0;
    int  cyc = 0, last_pop = 0, n_writes = 0;
    bit  tx_force = 0, tx_rand = 0, gap_mode = 0;
    u8_t m_led = 8'h00, m_err = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int hexval(input u8_t c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic u8_t hexch(input int n);
        string d;
        d = "0123456789ABCDEF";
        return u8_t'(d[n]);
    endfunction

    function automatic void bump_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endfunction

    // Reference interpreter over a complete byte string; a command cut short is a timeout.
    task automatic model(input u8_t b[$]);
        int  i;
        int  hi, lo;
        u8_t c, v;
        i = 0;
        while (i < b.size()) begin
            c = b[i];
            i++;
            if (c == 8'h4C || c == 8'h54) begin
                if (i >= b.size()) begin bump_err(); break; end
                hi = hexval(b[i]);
                i++;
                if (hi < 0) begin bump_err(); exp_q.push_back(8'h3F); continue; end
                if (i >= b.size()) begin bump_err(); break; end
                lo = hexval(b[i]);
                i++;
                if (lo < 0) begin bump_err(); exp_q.push_back(8'h3F); continue; end
                v = u8_t'(hi * 16 + lo);
                m_led = (c == 8'h4C) ? v : (m_led ^ v);
                exp_q.push_back(8'h4B);
            end else if (c == 8'h52) begin
                exp_q.push_back(hexch(int'(m_led) / 16));
                exp_q.push_back(hexch(int'(m_led) % 16));
                exp_q.push_back(8'h0A);
            end else if (c != 8'h0D && c != 8'h0A) begin
                bump_err();
                exp_q.push_back(8'h3F);
            end
        end
    endtask

    task automatic send(input u8_t b[$]);
        model(b);
        foreach (b[i]) rx_q.push_back(b[i]);
    endtask

    task automatic send_str(input string s);
        u8_t b[$];
        for (int i = 0; i < s.len(); i++) b.push_back(u8_t'(s[i]));
        send(b);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && !busy) done = 1;
        end
        check({name, "_idle"}, 32'(done), 32'd1);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_led"}, 32'(led), 32'(m_led));
        check({name, "_err"}, 32'(err_count), 32'(m_err));
    endtask

    function automatic u8_t rand_hex();
        int n;
        n = $urandom_range(0, 15);
        if (n < 10) return u8_t'(48 + n);
        return u8_t'(($urandom_range(0, 1) != 0 ? 55 : 87) + n);
    endfunction

    function automatic u8_t rand_nonhex();
        u8_t c;
        do c = u8_t'($urandom_range(0, 255)); while (hexval(c) >= 0);
        return c;
    endfunction

    function automatic u8_t rand_badcmd();
        u8_t c;
        do c = u8_t'($urandom_range(0, 255));
        while (c == 8'h4C || c == 8'h54 || c == 8'h52 || c == 8'h0D || c == 8'h0A);
        return c;
    endfunction

    task automatic rand_cmd(output u8_t b[$]);
        b.delete();
        case ($urandom_range(0, 5))
            0: begin b.push_back(8'h4C); b.push_back(rand_hex()); b.push_back(rand_hex()); end
            1: begin b.push_back(8'h54); b.push_back(rand_hex()); b.push_back(rand_hex()); end
            2: b.push_back(8'h52);
            3: b.push_back($urandom_range(0, 1) != 0 ? 8'h0D : 8'h0A);
            4: b.push_back(rand_badcmd());
            default: begin
                b.push_back($urandom_range(0, 1) != 0 ? 8'h4C : 8'h54);
                if ($urandom_range(0, 1) != 0) b.push_back(rand_hex());
                b.push_back(rand_nonhex());
            end
        endcase
    endtask

    task automatic run_random(input int it);
        int  nb;
        u8_t b[$];
        nb = $urandom_range(1, 4);
        for (int j = 0; j < nb; j++) begin
            rand_cmd(b);
            send(b);
        end
        wait_idle($sformatf("rand%0d", it));
    endtask

    // RX/TX FIFO model: pops on the edge, presents new flags just after it.
    initial begin
        bus.rx_empty  = 1'b1;
        bus.read_data = 8'h00;
        bus.tx_full   = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.read_uart) begin
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                last_pop = cyc;
            end
            cyc++;
            #1;
            bus.tx_full   = tx_force || (tx_rand && $urandom_range(0, 2) == 0);
            bus.rx_empty  = (rx_q.size() == 0) || (gap_mode && $urandom_range(0, 3) == 0);
            bus.read_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
    end

    // Reply monitor: every push must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.read_uart) check("pop_while_empty", 32'(bus.rx_empty), 32'd0);
            if (bus.write_uart) begin
                check("push_while_full", 32'(bus.tx_full), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push actual=%0h expected=none", bus.write_data);
                end else begin
                    u8_t e;
                    e = exp_q.pop_front();
                    check("reply_byte", 32'(bus.write_data), 32'(e));
                end
                wr_cyc.push_back(cyc);
                n_writes++;
            end
        end
    end

    initial begin
        int  w0, n;
        bit  seen;
        u8_t crlf[$];

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_write_uart", 32'(bus.write_uart), 32'd0);
        check("rst_read_uart", 32'(bus.read_uart), 32'd0);
        check("rst_write_data", 32'(bus.write_data), 32'd0);
        rst = 1'b1;

        send_str("L5A"); wait_idle("load");
        send_str("T0F"); wait_idle("toggle");
        send_str("LC3"); wait_idle("load_c3");

        send_str("R"); wait_idle("read");
        n = wr_cyc.size();
        check("read_first_latency", 32'(wr_cyc[n-3] - last_pop), 32'd2);
        check("read_last_latency", 32'(wr_cyc[n-1] - last_pop), 32'd4);

        tx_force = 1;
        w0 = n_writes;
        send_str("R");
        repeat (8) @(negedge clk);
        check("stall_no_push", 32'(n_writes - w0), 32'd0);
        tx_force = 0;
        wait_idle("read_stall");

        send_str("LZ"); wait_idle("bad_digit");
        send_str("X");  wait_idle("bad_cmd");
        crlf.push_back(8'h0D);
        crlf.push_back(8'h0A);
        send(crlf); wait_idle("crlf");

        send_str("L4"); wait_idle("timeout");
        check("timeout_duration", 32'((cyc - last_pop) >= int'(T_OUT)), 32'd1);
        send_str("R"); wait_idle("read_after_timeout");

        tx_rand = 1;
        gap_mode = 1;
        for (int it = 0; it < 60; it++) run_random(it);
        tx_rand = 0;
        gap_mode = 0;

        send_str("L96"); wait_idle("pre_reset");
        w0 = n_writes;
        send_str("R");
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (n_writes > w0) seen = 1;
        end
        check("reset_reply_started", 32'(seen), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_err", 32'(err_count), 32'd0);
        check("async_rst_write_uart", 32'(bus.write_uart), 32'd0);
        check("async_rst_write_data", 32'(bus.write_data), 32'd0);
        m_led = 8'h00;
        m_err = 8'h00;
        exp_q.delete();
        w0 = n_writes;
        repeat (4) @(negedge clk);
        check("no_push_in_reset", 32'(n_writes - w0), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("no_push_after_reset", 32'(n_writes - w0), 32'd0);
        send_str("L01"); wait_idle("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
